// File: rtl/alu_arb_ctrl.sv
// Two-requester front end for a shared registered ALU: round-robin grant, one
// command in flight, error commands answered directly without touching the ALU.
module alu_arb_ctrl #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID0,
    input  logic             REQ_VALID1,
    input  logic [WIDTH-1:0] REQ_A0,
    input  logic [WIDTH-1:0] REQ_B0,
    input  logic [WIDTH-1:0] REQ_A1,
    input  logic [WIDTH-1:0] REQ_B1,
    input  logic [FUN_W-1:0] REQ_FUN0,
    input  logic [FUN_W-1:0] REQ_FUN1,
    output logic             REQ_READY0,
    output logic             REQ_READY1,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [FUN_W-1:0] ALU_FUN,
    input  logic [WIDTH-1:0] ALU_RES,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic             RSP_ID,
    output logic             RSP_ERR,
    output logic             BUSY
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [FUN_W-1:0] FUN_DIV   = FUN_W'(3);
    localparam logic [FUN_W-1:0] FUN_UNDEF = {FUN_W{1'b1}};

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [FUN_W-1:0] fun_q, fun_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [FUN_W-1:0] sel_fun;
    logic             sel_err;

    // prio_q names the requester that wins a tie
    assign gnt     = (REQ_VALID0 & REQ_VALID1) ? prio_q : REQ_VALID1;
    assign sel_a   = gnt ? REQ_A1 : REQ_A0;
    assign sel_b   = gnt ? REQ_B1 : REQ_B0;
    assign sel_fun = gnt ? REQ_FUN1 : REQ_FUN0;
    assign sel_err = (sel_fun == FUN_UNDEF) || ((sel_fun == FUN_DIV) && (sel_b == '0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        REQ_READY0  = 1'b0;
        REQ_READY1  = 1'b0;
        ALU_A       = '0;
        ALU_B       = '0;
        ALU_FUN     = FUN_UNDEF;
        case (state_q)
            IDLE: begin
                REQ_READY0 = REQ_VALID0 & ~gnt;
                REQ_READY1 = REQ_VALID1 & gnt;
                if (REQ_VALID0 | REQ_VALID1) begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    fun_d  = sel_fun;
                    id_d   = gnt;
                    prio_d = ~gnt;
                    if (sel_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_id_d    = gnt;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                ALU_A   = a_q;
                ALU_B   = b_q;
                ALU_FUN = fun_q;
                state_d = WAIT;
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = ALU_RES;
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Random and directed bench for alu_arb_ctrl against a transaction-level model
// (grant order, response contents and response latency) plus a registered ALU.
module tb_alu_arb_ctrl;
    localparam int W = 16;
    localparam int F = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ_VALID0 = 0, REQ_VALID1 = 0;
    logic [W-1:0] REQ_A0 = 0, REQ_B0 = 0, REQ_A1 = 0, REQ_B1 = 0;
    logic [F-1:0] REQ_FUN0 = 0, REQ_FUN1 = 0;
    logic         REQ_READY0, REQ_READY1;
    logic [W-1:0] ALU_A, ALU_B;
    logic [F-1:0] ALU_FUN;
    logic [W-1:0] ALU_RES = 0;
    logic         RSP_VALID;
    logic         RSP_READY = 1;
    logic [W-1:0] RSP_DATA;
    logic         RSP_ID, RSP_ERR, BUSY;

    int n_chk = 0;
    int n_err = 0;

    alu_arb_ctrl #(.WIDTH(W), .FUN_W(F)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID0(REQ_VALID0), .REQ_VALID1(REQ_VALID1),
        .REQ_A0(REQ_A0), .REQ_B0(REQ_B0), .REQ_A1(REQ_A1), .REQ_B1(REQ_B1),
        .REQ_FUN0(REQ_FUN0), .REQ_FUN1(REQ_FUN1),
        .REQ_READY0(REQ_READY0), .REQ_READY1(REQ_READY1),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_RES(ALU_RES),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [F-1:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 0) ? '0 : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << b[3:0];
            4'd8:    return a >> b[3:0];
            4'd9:    return W'(a < b);
            4'd10:   return W'(a == b);
            default: return ~a;
        endcase
    endfunction

    // Registered ALU: result appears one edge after its inputs
    always @(posedge CLK) ALU_RES <= alu_f(ALU_A, ALU_B, ALU_FUN);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model state: in-flight command, cycles since its acceptance, tie winner
    logic         busy_m = 0, err_m = 0, prio_m = 0, rst_prev = 0;
    int           k = 0;
    logic [W-1:0] ca, cb, exp_d;
    logic [F-1:0] cf;
    logic         cid;
    int           accepts[$];

    task automatic step();
        logic g, issue, rv;
        if (rst_prev) begin
            chk("rst_valid", 32'(RSP_VALID), 0);
            chk("rst_data", 32'(RSP_DATA), 0);
            chk("rst_id", 32'(RSP_ID), 0);
            chk("rst_err", 32'(RSP_ERR), 0);
            chk("rst_busy", 32'(BUSY), 0);
            chk("rst_alu_fun", 32'(ALU_FUN), 32'hF);
        end
        rst_prev = RST;
        if (RST) begin
            busy_m = 0; prio_m = 0; k = 0;
            return;
        end
        if (busy_m) k++;
        if (!busy_m) begin
            g = (REQ_VALID0 && REQ_VALID1) ? prio_m : REQ_VALID1;
            chk("busy_idle", 32'(BUSY), 0);
            chk("ready0", 32'(REQ_READY0), 32'(REQ_VALID0 && !g));
            chk("ready1", 32'(REQ_READY1), 32'(REQ_VALID1 && g));
            chk("rsp_valid_idle", 32'(RSP_VALID), 0);
            chk("alu_idle", {ALU_A, ALU_B} == 0 ? 32'(ALU_FUN) : 32'hDEAD, 32'hF);
            if (REQ_VALID0 || REQ_VALID1) begin
                cid = g;
                ca  = g ? REQ_A1 : REQ_A0;
                cb  = g ? REQ_B1 : REQ_B0;
                cf  = g ? REQ_FUN1 : REQ_FUN0;
                err_m  = (cf == 4'hF) || (cf == 4'h3 && cb == 0);
                exp_d  = err_m ? '0 : alu_f(ca, cb, cf);
                busy_m = 1; k = 0; prio_m = !g;
                accepts.push_back(int'(g));
            end
        end else begin
            chk("busy", 32'(BUSY), 1);
            chk("ready_busy", 32'({REQ_READY1, REQ_READY0}), 0);
            issue = !err_m && k == 1;
            chk("alu_a", 32'(ALU_A), issue ? 32'(ca) : 0);
            chk("alu_b", 32'(ALU_B), issue ? 32'(cb) : 0);
            chk("alu_fun", 32'(ALU_FUN), issue ? 32'(cf) : 32'hF);
            rv = err_m || k >= 3;
            chk("rsp_valid", 32'(RSP_VALID), 32'(rv));
            if (rv) begin
                chk("rsp_data", 32'(RSP_DATA), 32'(exp_d));
                chk("rsp_id", 32'(RSP_ID), 32'(cid));
                chk("rsp_err", 32'(RSP_ERR), 32'(err_m));
                if (RSP_READY) busy_m = 0;
            end
        end
    endtask

    // Inputs are set just after a rising edge; tick checks at the falling edge
    task automatic tick();
        @(negedge CLK);
        step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REQ_VALID0 = 0; REQ_VALID1 = 0; RSP_READY = 1; RST = 0;
    endtask

    task automatic do_reset();
        RST = 1; tick(); tick(); RST = 0;
    endtask

    initial begin
        logic hit;
        do_reset();

        // Simple add from requester 0
        REQ_VALID0 = 1; REQ_A0 = 16'h3; REQ_B0 = 16'h4; REQ_FUN0 = 4'h0;
        tick();
        REQ_VALID0 = 0;
        repeat (5) tick();
        chk("add_result", 32'(exp_d), 32'h7);

        // Both requesters held: grants alternate starting at 0
        do_reset();
        accepts.delete();
        REQ_VALID0 = 1; REQ_VALID1 = 1; REQ_FUN0 = 4'hA; REQ_FUN1 = 4'hA;
        REQ_A0 = 16'h55; REQ_B0 = 16'h55; REQ_A1 = 16'h1234; REQ_B1 = 16'h1234;
        repeat (16) tick();
        idle_inputs();
        repeat (4) tick();
        chk("rr_count", 32'(accepts.size()), 4);
        for (int i = 0; i < accepts.size() && i < 4; i++)
            chk("rr_order", 32'(accepts[i]), 32'(i % 2));

        // Divide by zero from requester 1
        REQ_VALID1 = 1; REQ_FUN1 = 4'h3; REQ_A1 = 16'h9; REQ_B1 = 16'h0;
        tick();
        REQ_VALID1 = 0;
        repeat (3) tick();

        // Subtract with consumer stalling
        REQ_VALID0 = 1; REQ_FUN0 = 4'h1; REQ_A0 = 16'h10; REQ_B0 = 16'h1; RSP_READY = 0;
        tick();
        REQ_VALID0 = 0;
        repeat (8) tick();
        chk("sub_result", 32'(exp_d), 32'hF);
        RSP_READY = 1;
        repeat (3) tick();

        // Reset while waiting on the ALU, then a requester-1-only command
        hit = 0;
        REQ_VALID1 = 1; REQ_FUN1 = 4'h0; REQ_A1 = 16'h21; REQ_B1 = 16'h2;
        tick();
        REQ_VALID1 = 0;
        for (int i = 0; i < 6 && !hit; i++) begin
            if (busy_m && !err_m && k == 1) begin
                RST = 1; hit = 1;
            end
            tick();
        end
        chk("rst_in_wait", 32'(hit), 1);
        RST = 0;
        REQ_VALID1 = 1; REQ_FUN1 = 4'h6;
        tick();
        REQ_VALID1 = 0;
        repeat (4) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            REQ_VALID0 = ($urandom_range(0, 2) == 0);
            REQ_VALID1 = ($urandom_range(0, 2) == 0);
            REQ_A0 = W'($urandom); REQ_A1 = W'($urandom);
            REQ_B0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            REQ_B1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            REQ_FUN0 = F'($urandom); REQ_FUN1 = F'($urandom);
            RSP_READY = ($urandom_range(0, 3) != 0);
            RST = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Parameter: FUN_W, 4, ALU function-code width in bits.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  in  1  synchronous reset, active-high.
REQ-005 Port: REQ_VALID0, REQ_VALID1  in  1 each  requester 0/1 holds a valid command.
REQ-006 Port: REQ_A0, REQ_B0, REQ_A1, REQ_B1  in  WIDTH each  operands A and B per requester.
REQ-007 Port: REQ_FUN0, REQ_FUN1  in  FUN_W each  ALU function code per requester.
REQ-008 Port: REQ_READY0, REQ_READY1  out  1 each  command accepted on an edge where VALID and READY are both 1.
REQ-009 Port: ALU_A, ALU_B  out  WIDTH each  operands driven to the shared ALU.
REQ-010 Port: ALU_FUN  out  FUN_W  function code driven to the shared ALU.
REQ-011 Port: ALU_RES  in  WIDTH  registered ALU result, valid one clock edge after its inputs were applied.
REQ-012 Port: RSP_VALID  out  1  response available.
REQ-013 Port: RSP_READY  in  1  consumer accepts the response.
REQ-014 Port: RSP_DATA  out  WIDTH  result value.
REQ-015 Port: RSP_ID  out  1  index of the requester that issued the command.
REQ-016 Port: RSP_ERR  out  1  command rejected without execution.
REQ-017 Port: BUSY  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; the block SHALL hold at most one command in flight.
REQ-019 In IDLE, REQ_READYx SHALL be 1 only for the granted requester; both READYs SHALL be 0 in all other states.
REQ-020 Grant SHALL be round-robin: with a single valid requester, that requester wins; with both valid, the requester not served last wins; the priority pointer SHALL update only on acceptance.
REQ-021 On acceptance, the block SHALL register A, B, FUN and ID, then go to ISSUE, or to RESP for an error command.
REQ-022 An error command is FUN 4'b0011 with B==0 (divide by zero) or FUN 4'b1111 (undefined); it SHALL never be driven to the ALU.
REQ-023 For an error command, the cycle after acceptance SHALL show RSP_VALID=1, RSP_ERR=1 and RSP_DATA=0.
REQ-024 In ISSUE, ALU_A, ALU_B and ALU_FUN SHALL carry the registered command for exactly one cycle, then the FSM goes to WAIT.
REQ-025 Outside ISSUE, the ALU outputs SHALL be ALU_A=0, ALU_B=0 and ALU_FUN=4'b1111.
REQ-026 In WAIT, the block SHALL capture ALU_RES into RSP_DATA on the edge, set RSP_VALID=1 and RSP_ERR=0, and go to RESP.
REQ-027 For a normal command accepted on edge t, RSP_VALID SHALL first be high in the cycle after edge t+2.
REQ-028 RSP_DATA SHALL be ALU_RES passed through unmodified; truncation of multiply results is defined by the ALU.
REQ-029 In RESP, RSP_VALID, RSP_DATA, RSP_ID and RSP_ERR SHALL be held stable until an edge with RSP_READY=1; on that edge RSP_VALID clears and the FSM goes to IDLE.
REQ-030 A new command SHALL be accepted no earlier than the cycle after the response handshake; back-to-back throughput is one command per 4 cycles.
REQ-031 Requester inputs that change while not accepted SHALL have no effect; a deasserted VALID SHALL withdraw its request without error.

Reset
REQ-032 While RST=1 at an edge, the block SHALL enter IDLE with the priority pointer at requester 0.
REQ-033 Reset values SHALL be RSP_VALID=0, RSP_DATA=0, RSP_ID=0, RSP_ERR=0 and BUSY=0, with the ALU outputs at their idle values.
REQ-034 Reset in any state SHALL drop the in-flight command with no response generated; RST has priority over every other event on the same edge.

Verification
REQ-035 Req0: A=0x0003, B=0x0004, FUN=0000, RSP_READY=1 -> RSP_VALID in the cycle after edge t+2 with DATA=0x0007, ID=0, ERR=0; BUSY low again one cycle later.
REQ-036 Both VALIDs held high from reset with FUN=1010 and A=B -> accepts go 0,1,0,1, each 4 cycles apart, each with DATA=0x0001.
REQ-037 Req1: FUN=0011, B=0x0000 -> ALU_FUN stays 1111 throughout; next cycle RSP_VALID=1, ERR=1, DATA=0, ID=1.
REQ-038 RSP_READY held low for 5 cycles after a SUB of 0x0010-0x0001 -> DATA=0x000F stable across all 5 cycles; both REQ_READYs 0 until one cycle after the handshake.
REQ-039 RST pulsed during WAIT -> next cycle shows all outputs at reset values and no response; a subsequent req1-only command is granted immediately.
